// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, single-outstanding imem handshake,
// IR plus one-entry skid buffer, stall handling and branch redirect with in-flight drain.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] PC_INC   = 64'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_addr,
    output logic [63:0] IR,
    output logic        ir_valid,
    output logic [63:0] ir_pc
);

    typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        imem_req_q, imem_req_d;
    logic [63:0] imem_addr_q, imem_addr_d;
    logic [63:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [63:0] ir_pc_q, ir_pc_d;
    logic [63:0] skid_q, skid_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic        skid_valid_q, skid_valid_d;

    logic consume, slot_free, ack;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        ir_pc_d      = ir_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;

        consume   = ir_valid_q & ~stall;
        slot_free = ~ir_valid_q | consume;
        // An ack only counts against a request we actually presented.
        ack       = imem_ack & imem_req_q;

        if (redirect_valid) begin
            ir_d         = 64'h0;
            ir_valid_d   = 1'b0;
            ir_pc_d      = 64'h0;
            skid_valid_d = 1'b0;
            fetch_pc_d   = {redirect_addr[63:3], 3'b000};
            state_d      = (imem_req_q && !ack) ? S_DRAIN : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (consume) begin
                        ir_d       = 64'h0;
                        ir_valid_d = 1'b0;
                    end
                    if (ack) begin
                        fetch_pc_d = fetch_pc_q + PC_INC;
                        if (slot_free && skid_valid_q) begin
                            ir_d       = skid_q;
                            ir_pc_d    = skid_pc_q;
                            ir_valid_d = 1'b1;
                            skid_d     = imem_rdata;
                            skid_pc_d  = imem_addr_q;
                        end else if (slot_free) begin
                            ir_d       = imem_rdata;
                            ir_pc_d    = imem_addr_q;
                            ir_valid_d = 1'b1;
                        end else begin
                            skid_d       = imem_rdata;
                            skid_pc_d    = imem_addr_q;
                            skid_valid_d = 1'b1;
                        end
                    end else if (slot_free && skid_valid_q) begin
                        ir_d         = skid_q;
                        ir_pc_d      = skid_pc_q;
                        ir_valid_d   = 1'b1;
                        skid_valid_d = 1'b0;
                    end
                    state_d = skid_valid_d ? S_FULL : S_FETCH;
                end
                S_FULL: begin
                    if (consume) begin
                        ir_d         = skid_q;
                        ir_pc_d      = skid_pc_q;
                        ir_valid_d   = 1'b1;
                        skid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ack) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        // Request/address are registered from the next state; a drain keeps the
        // abandoned address on the bus until memory acks it.
        imem_req_d  = (state_d != S_FULL);
        imem_addr_d = (state_d == S_DRAIN) ? imem_addr_q : fetch_pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            ir_q         <= 64'h0;
            ir_valid_q   <= 1'b0;
            ir_pc_q      <= 64'h0;
            skid_q       <= 64'h0;
            skid_pc_q    <= 64'h0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            ir_pc_q      <= ir_pc_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign IR        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign ir_pc     = ir_pc_q;

endmodule
